// File: rtl/radio_pkg.sv
// Shared definitions for the radio receive path: word geometry, the position
// of each 2-bit radio field inside a sample word and the alignment FSM encoding.
package radio_pkg;

    // Bits per serial word; bit 0 is transmitted first.
    localparam int WORD_W    = 8;
    localparam int BIT_CNT_W = $clog2(WORD_W);

    // Each radio field is two bits wide. These are the LSB positions of each field in a word.
    localparam int FIELD_W   = 2;
    localparam int R0_I_LSB  = 6;
    localparam int R0_Q_LSB  = 4;
    localparam int R1_I_LSB  = 2;
    localparam int R1_Q_LSB  = 0;

    // Alignment FSM. The member names carry a prefix so they cannot collide
    // with the LOCKED output port of the deserializer.
    typedef enum logic {
        STATE_HUNT   = 1'b0,
        STATE_LOCKED = 1'b1
    } deserState_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear. It stops at all-ones and
// never wraps, so a long run of events still reads as "a lot" and never as a small number.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear wins over increment, and the increment holds at all-ones.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/radio_deserializer.sv
// Receive-side deserializer for the radio bit stream. It rebuilds 8-bit sample
// words from DATA_IN, LSB first, and uses SYNC_IN for alignment. Each word is
// split into the R0_I/R0_Q/R1_I/R1_Q fields. A hunt/locked FSM tracks
// alignment, and misaligned SYNC pulses are counted for the correlator.
// Optional feature: define RADIO_DESER_WORD_CNT_EN to add the 32-bit WORD_CNT
// output, which counts every emitted word.
module radio_deserializer
    import radio_pkg::*;
#(
    parameter int ERR_CNT_W      = 16,
    parameter int MAX_FREE_WORDS = 64
) (
    input  logic                 SYS_CLK,
    input  logic                 SYS_RST,
    input  logic                 DATA_IN,
    input  logic                 SYNC_IN,
    output logic [WORD_W-1:0]    WORD_OUT,
    output logic                 WORD_VALID,
    output logic [FIELD_W-1:0]   R0_I,
    output logic [FIELD_W-1:0]   R0_Q,
    output logic [FIELD_W-1:0]   R1_I,
    output logic [FIELD_W-1:0]   R1_Q,
    output logic                 LOCKED,
    output logic [ERR_CNT_W-1:0] SYNC_ERR_CNT
`ifdef RADIO_DESER_WORD_CNT_EN
    ,
    output logic [31:0]          WORD_CNT
`endif
);

    // The free-word counter only has to reach MAX_FREE_WORDS. When the
    // timeout is disabled (value 0), the counter is kept at a single idle bit.
    localparam int FREE_W = (MAX_FREE_WORDS > 0) ? $clog2(MAX_FREE_WORDS + 1) : 1;
    localparam logic [FREE_W-1:0]    FREE_LIMIT = FREE_W'(MAX_FREE_WORDS);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT   = BIT_CNT_W'(WORD_W - 1);

    deserState_e          state_q,     state_d;
    logic [BIT_CNT_W-1:0] bitCnt_q,    bitCnt_d;
    logic [WORD_W-1:0]    shift_q,     shift_d;
    logic [WORD_W-1:0]    wordOut_q,   wordOut_d;
    logic                 wordValid_q, wordValid_d;
    logic [FREE_W-1:0]    freeCnt_q,   freeCnt_d;
    logic                 syncErrInc;

    // Next-state logic for the alignment FSM, the bit assembly and the word output.
    always_comb begin
        state_d     = state_q;
        bitCnt_d    = bitCnt_q;
        shift_d     = shift_q;
        wordOut_d   = wordOut_q;
        wordValid_d = 1'b0;
        freeCnt_d   = freeCnt_q;
        syncErrInc  = 1'b0;

        case (state_q)
            STATE_HUNT: begin
                // Ignore the line until a SYNC marks bit 0 of a word. The word
                // started here counts as the first free-running word.
                if (SYNC_IN) begin
                    shift_d    = '0;
                    shift_d[0] = DATA_IN;
                    bitCnt_d   = BIT_CNT_W'(1);
                    freeCnt_d  = '0;
                    state_d    = STATE_LOCKED;
                end
            end

            STATE_LOCKED: begin
                if (SYNC_IN && (bitCnt_q != '0)) begin
                    // A SYNC in the middle of a word means the transmitter
                    // restarted. Drop the partial word and realign here.
                    syncErrInc = 1'b1;
                    shift_d    = '0;
                    shift_d[0] = DATA_IN;
                    bitCnt_d   = BIT_CNT_W'(1);
                end else begin
                    if (SYNC_IN) begin
                        freeCnt_d = '0;
                    end
                    shift_d[bitCnt_q] = DATA_IN;
                    if (bitCnt_q == LAST_BIT) begin
                        bitCnt_d    = '0;
                        wordOut_d   = shift_d;
                        wordValid_d = 1'b1;
                        if (MAX_FREE_WORDS != 0) begin
                            freeCnt_d = freeCnt_d + FREE_W'(1);
                            if (freeCnt_d == FREE_LIMIT) begin
                                state_d = STATE_HUNT;
                            end
                        end
                    end else begin
                        bitCnt_d = bitCnt_q + BIT_CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = STATE_HUNT;
            end
        endcase
    end

    // State and datapath registers. The synchronous reset also discards any partial word.
    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            state_q     <= STATE_HUNT;
            bitCnt_q    <= '0;
            shift_q     <= '0;
            wordOut_q   <= '0;
            wordValid_q <= 1'b0;
            freeCnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            bitCnt_q    <= bitCnt_d;
            shift_q     <= shift_d;
            wordOut_q   <= wordOut_d;
            wordValid_q <= wordValid_d;
            freeCnt_q   <= freeCnt_d;
        end
    end

    sat_counter #(
        .WIDTH (ERR_CNT_W)
    ) u_syncErrCnt (
        .clk_i   (SYS_CLK),
        .rst_i   (SYS_RST),
        .inc_i   (syncErrInc),
        .clr_i   (1'b0),
        .count_o (SYNC_ERR_CNT)
    );

`ifdef RADIO_DESER_WORD_CNT_EN
    logic [31:0] wordCnt_q;

    // Word counter. It steps on the same edge that loads WORD_OUT, so it
    // already includes the word being presented. It wraps naturally.
    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            wordCnt_q <= '0;
        end else if (wordValid_d) begin
            wordCnt_q <= wordCnt_q + 32'd1;
        end
    end

    assign WORD_CNT = wordCnt_q;
`endif

    assign WORD_OUT   = wordOut_q;
    assign WORD_VALID = wordValid_q;
    assign R0_I       = wordOut_q[R0_I_LSB +: FIELD_W];
    assign R0_Q       = wordOut_q[R0_Q_LSB +: FIELD_W];
    assign R1_I       = wordOut_q[R1_I_LSB +: FIELD_W];
    assign R1_Q       = wordOut_q[R1_Q_LSB +: FIELD_W];
    assign LOCKED     = (state_q == STATE_LOCKED);

endmodule

// File: tb/tb_radio_deserializer.sv
// Directed bench for radio_deserializer. Three instances share one stimulus
// stream: A uses the default parameters, B has a 2-bit error counter, and C
// has a four-word free-running timeout. Set RADIO_DESER_WORD_CNT_EN to also
// exercise WORD_CNT.
module tb_radio_deserializer;

    logic sysClk = 1'b0;
    logic sysRst = 1'b1;
    logic dataIn = 1'b0;
    logic syncIn = 1'b0;

    logic [7:0]  wordOutA, wordOutB, wordOutC;
    logic        validA, validB, validC;
    logic [1:0]  r0iA, r0qA, r1iA, r1qA;
    logic [1:0]  r0iB, r0qB, r1iB, r1qB;
    logic [1:0]  r0iC, r0qC, r1iC, r1qC;
    logic        lockedA, lockedB, lockedC;
    logic [15:0] errA, errC;
    logic [1:0]  errB;
`ifdef RADIO_DESER_WORD_CNT_EN
    logic [31:0] wordCntA, wordCntB, wordCntC;
`endif

    int checks   = 0;
    int failures = 0;
    int strobesA = 0;
    int strobesC = 0;
    int markA;
    int markC;

    radio_deserializer dutA (
        .SYS_CLK(sysClk), .SYS_RST(sysRst), .DATA_IN(dataIn), .SYNC_IN(syncIn),
        .WORD_OUT(wordOutA), .WORD_VALID(validA),
        .R0_I(r0iA), .R0_Q(r0qA), .R1_I(r1iA), .R1_Q(r1qA),
        .LOCKED(lockedA), .SYNC_ERR_CNT(errA)
`ifdef RADIO_DESER_WORD_CNT_EN
        , .WORD_CNT(wordCntA)
`endif
    );

    radio_deserializer #(.ERR_CNT_W(2)) dutB (
        .SYS_CLK(sysClk), .SYS_RST(sysRst), .DATA_IN(dataIn), .SYNC_IN(syncIn),
        .WORD_OUT(wordOutB), .WORD_VALID(validB),
        .R0_I(r0iB), .R0_Q(r0qB), .R1_I(r1iB), .R1_Q(r1qB),
        .LOCKED(lockedB), .SYNC_ERR_CNT(errB)
`ifdef RADIO_DESER_WORD_CNT_EN
        , .WORD_CNT(wordCntB)
`endif
    );

    radio_deserializer #(.MAX_FREE_WORDS(4)) dutC (
        .SYS_CLK(sysClk), .SYS_RST(sysRst), .DATA_IN(dataIn), .SYNC_IN(syncIn),
        .WORD_OUT(wordOutC), .WORD_VALID(validC),
        .R0_I(r0iC), .R0_Q(r0qC), .R1_I(r1iC), .R1_Q(r1qC),
        .LOCKED(lockedC), .SYNC_ERR_CNT(errC)
`ifdef RADIO_DESER_WORD_CNT_EN
        , .WORD_CNT(wordCntC)
`endif
    );

    // Free-running bit clock
    always #5 sysClk = ~sysClk;

    // Count strobes mid-cycle. A WORD_VALID pulse lasts exactly one cycle, so
    // each pulse is seen exactly once here.
    always @(negedge sysClk) begin
        if (validA === 1'b1) strobesA++;
        if (validC === 1'b1) strobesC++;
    end

    // Drive one bit on the falling edge, then return 1 ns after the rising
    // edge that samples it.
    task automatic applyStimulus(input logic d, input logic s, input logic r);
        @(negedge sysClk);
        dataIn = d;
        syncIn = s;
        sysRst = r;
        @(posedge sysClk);
        #1;
    endtask

    // Send a whole word LSB first, optionally with SYNC on bit 0.
    task automatic sendWord(input logic [7:0] w, input logic s);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(w[i], (i == 0) ? s : 1'b0, 1'b0);
        end
    endtask

    // Hold reset for three cycles.
    task automatic doReset();
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);
    endtask

    // Compare one observation against its hand-computed value.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Directed test sequence
    initial begin
        $display("[TB] reset and first aligned word");
        doReset();
        checkOutput("rst_word",   32'(wordOutA), 32'h00);
        checkOutput("rst_valid",  32'(validA),   32'h0);
        checkOutput("rst_r0i",    32'(r0iA),     32'h0);
        checkOutput("rst_r1q",    32'(r1qA),     32'h0);
        checkOutput("rst_locked", 32'(lockedA),  32'h0);
        checkOutput("rst_err",    32'(errA),     32'h0);
`ifdef RADIO_DESER_WORD_CNT_EN
        checkOutput("rst_wcnt",   wordCntA,      32'h0);
`endif
        markA = strobesA;
        sendWord(8'hB4, 1'b1);
        checkOutput("b4_valid",  32'(validA),   32'h1);
        checkOutput("b4_word",   32'(wordOutA), 32'hB4);
        checkOutput("b4_r0i",    32'(r0iA),     32'h2);
        checkOutput("b4_r0q",    32'(r0qA),     32'h3);
        checkOutput("b4_r1i",    32'(r1iA),     32'h1);
        checkOutput("b4_r1q",    32'(r1qA),     32'h0);
        checkOutput("b4_locked", 32'(lockedA),  32'h1);
        checkOutput("b4_err",    32'(errA),     32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("b4_pulse_end", 32'(validA),       32'h0);
        checkOutput("b4_strobes",   32'(strobesA - markA), 32'd1);

        $display("[TB] noise before SYNC, then 0x01 and 0xFF");
        doReset();
        markA = strobesA;
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("hunt_locked", 32'(lockedA), 32'h0);
        checkOutput("hunt_valid",  32'(validA),  32'h0);
        sendWord(8'h01, 1'b1);
        checkOutput("w01_word", 32'(wordOutA), 32'h01);
        sendWord(8'hFF, 1'b1);
        checkOutput("wff_word", 32'(wordOutA), 32'hFF);
        checkOutput("wff_r0i",  32'(r0iA),     32'h3);
        checkOutput("wff_r1q",  32'(r1qA),     32'h3);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("two_strobes", 32'(strobesA - markA), 32'd2);
        checkOutput("aligned_err", 32'(errA),             32'h0);

        $display("[TB] SYNC at bit 3 of a word");
        doReset();
        markA = strobesA;
        sendWord(8'h5A, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        sendWord(8'h3C, 1'b1);
        checkOutput("realign_valid",  32'(validA),   32'h1);
        checkOutput("realign_word",   32'(wordOutA), 32'h3C);
        checkOutput("realign_err",    32'(errA),     32'h1);
        checkOutput("realign_locked", 32'(lockedA),  32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("realign_strobes", 32'(strobesA - markA), 32'd2);

        $display("[TB] repeated misaligned SYNC and saturation");
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("hunt_sync_err", 32'(errA), 32'h0);
        repeat (5) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            applyStimulus(1'b1, 1'b1, 1'b0);
        end
        checkOutput("err_five",  32'(errA), 32'd5);
        checkOutput("err_sat_b", 32'(errB), 32'd3);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("held_sync_err",   32'(errA), 32'd6);
        checkOutput("held_sync_sat_b", 32'(errB), 32'd3);

        $display("[TB] reset in the middle of a locked word");
        sendWord(8'h77, 1'b1);
        checkOutput("w77_word", 32'(wordOutA), 32'h77);
        checkOutput("w77_err",  32'(errA),     32'd7);
        markA = strobesA;
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("midrst_word",   32'(wordOutA), 32'h00);
        checkOutput("midrst_valid",  32'(validA),   32'h0);
        checkOutput("midrst_r0i",    32'(r0iA),     32'h0);
        checkOutput("midrst_locked", 32'(lockedA),  32'h0);
        checkOutput("midrst_err",    32'(errA),     32'h0);
        checkOutput("midrst_err_b",  32'(errB),     32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("midrst_no_word", 32'(strobesA - markA), 32'd1);
        checkOutput("midrst_hunt",    32'(lockedA),          32'h0);

        $display("[TB] free-running timeout");
        doReset();
        markA = strobesA;
        markC = strobesC;
        sendWord(8'h11, 1'b1);
        sendWord(8'h22, 1'b0);
        sendWord(8'h33, 1'b0);
`ifdef RADIO_DESER_WORD_CNT_EN
        checkOutput("wcnt_three", wordCntA, 32'd3);
`endif
        sendWord(8'h44, 1'b0);
        checkOutput("to_valid_c",  32'(validC),   32'h1);
        checkOutput("to_word_c",   32'(wordOutC), 32'h44);
        checkOutput("to_locked_c", 32'(lockedC),  32'h0);
        checkOutput("to_locked_a", 32'(lockedA),  32'h1);
        sendWord(8'h55, 1'b0);
        sendWord(8'h66, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("to_strobes_c", 32'(strobesC - markC), 32'd4);
        checkOutput("to_strobes_a", 32'(strobesA - markA), 32'd6);
        checkOutput("to_hold_c",    32'(wordOutC),         32'h44);
        checkOutput("to_hunt_c",    32'(lockedC),          32'h0);
        checkOutput("to_word_a",    32'(wordOutA),         32'h66);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
